mul_unsigned_rr_arb: RTL and testbench

//  Round-robin arbiter sharing one combinational mul_unsigned_for instance among

---
 rtl/mul_unsigned_rr_arb.sv | 187 ++++++++++++++++++
 tb/tb_mul_unsigned_rr_arb.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/mul_unsigned_rr_arb.sv
// Purpose : round-robin arbiter in front of one shared combinational unsigned multiplier.
// Latency : a grant taken at edge N produces rsp_valid=1 after edge N+1; an op takes at least 3 cycles.
// Backpr. : a response is held stable until rsp_ready=1. While busy, every req_ready bit is 0.
//
// Files in this unit:
//   mul_unsigned_for    - combinational WIDTH x WIDTH -> 2*WIDTH shift-add multiplier
//   mul_unsigned_rr_arb - arbiter, operand registers, FSM, registered response port
//
// Ports of mul_unsigned_rr_arb:
//   clk        in   1            clock, all state updates on posedge
//   rst        in   1            synchronous, active-high reset
//   req_valid  in   NREQ         requester i offers operands
//   req_ready  out  NREQ         one-hot grant. Operands of requester i are taken this cycle.
//   req_a      in   NREQ*WIDTH   operand a, slice i = [i*WIDTH +: WIDTH]
//   req_b      in   NREQ*WIDTH   operand b, slice i = [i*WIDTH +: WIDTH]
//   rsp_valid  out  1            result valid
//   rsp_ready  in   1            consumer accepts result
//   rsp_z      out  2*WIDTH      full-width unsigned product
//   rsp_id     out  IDW          index of the requester that produced rsp_z
//   busy       out  1            high whenever the FSM is not idle

// Purpose : unsigned multiply built from a loop of shifted partial products.
// Latency : purely combinational (0 cycles).
// Backpr. : none. The output follows the inputs.
module mul_unsigned_for #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic [2*WIDTH-1:0] z_o
);

  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] a_ext;

  always_comb begin
    a_ext = {{WIDTH{1'b0}}, a_i};
    acc   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (b_i[i]) begin
        acc = acc + (a_ext << i);
      end
    end
    z_o = acc;
  end

endmodule

// Purpose : NREQ-way round-robin front end for a shared mul_unsigned_for.
// Latency : grant at edge N -> CALC -> the result is registered at edge N+1 and is then valid.
// Backpr. : RESP holds until rsp_ready=1. No grants are made outside IDLE.
module mul_unsigned_rr_arb #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4,
  localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [2*WIDTH-1:0]    rsp_z,
  output logic [IDW-1:0]        rsp_id,
  output logic                  busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]         state_q,     state_d;
  logic [IDW-1:0]     rr_ptr_q,    rr_ptr_d;
  logic [WIDTH-1:0]   a_q,         a_d;
  logic [WIDTH-1:0]   b_q,         b_d;
  logic [IDW-1:0]     id_q,        id_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [2*WIDTH-1:0] rsp_z_q,     rsp_z_d;
  logic [IDW-1:0]     rsp_id_q,    rsp_id_d;

  logic               grant_found;
  logic [IDW-1:0]     grant_idx;
  logic [NREQ-1:0]    grant_onehot;
  logic               accept;
  logic [2*WIDTH-1:0] mul_z;
  int                 scan_idx;

  // The scan starts at rr_ptr and wraps modulo NREQ. The first valid requester wins.
  // Because rr_ptr moves past each winner, a waiting requester sees at most
  // NREQ-1 grants go to others before its own.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_idx    = 0;
    for (int k = 0; k < NREQ; k++) begin
      scan_idx = (int'(rr_ptr_q) + k) % NREQ;
      if (!grant_found && req_valid[scan_idx]) begin
        grant_found = 1'b1;
        grant_idx   = IDW'(scan_idx);
      end
    end
  end

  assign grant_onehot = NREQ'(1) << grant_idx;

  // The grant is masked during reset. Otherwise a requester could see a
  // handshake that the reset then discards.
  assign accept    = !rst && (state_q == IDLE) && grant_found;
  assign req_ready = accept ? grant_onehot : '0;

  mul_unsigned_for #(
    .WIDTH (WIDTH)
  ) u_mul (
    .a_i (a_q),
    .b_i (b_q),
    .z_o (mul_z)
  );

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    a_d         = a_q;
    b_d         = b_q;
    id_d        = id_q;
    rsp_valid_d = rsp_valid_q;
    rsp_z_d     = rsp_z_q;
    rsp_id_d    = rsp_id_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          a_d      = req_a[grant_idx*WIDTH +: WIDTH];
          b_d      = req_b[grant_idx*WIDTH +: WIDTH];
          id_d     = grant_idx;
          rr_ptr_d = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
          state_d  = CALC;
        end
      end
      CALC: begin
        rsp_z_d     = mul_z;
        rsp_id_d    = id_q;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        rsp_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      a_q         <= '0;
      b_q         <= '0;
      id_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_z_q     <= '0;
      rsp_id_q    <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      a_q         <= a_d;
      b_q         <= b_d;
      id_q        <= id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_z_q     <= rsp_z_d;
      rsp_id_q    <= rsp_id_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_z     = rsp_z_q;
  assign rsp_id    = rsp_id_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mul_unsigned_rr_arb.sv
// Purpose : directed self-checking bench for mul_unsigned_rr_arb (WIDTH=8, NREQ=4).
// Latency : inputs are driven and outputs sampled 1-2 time units after each posedge.
// Backpr. : the bench drives rsp_ready directly to hold the response.
module tb_mul_unsigned_rr_arb;

  localparam int WIDTH = 8;
  localparam int NREQ  = 4;
  localparam int IDW   = 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [2*WIDTH-1:0]    rsp_z;
  logic [IDW-1:0]        rsp_id;
  logic                  busy;

  int checks = 0;
  int errors = 0;

  int t3a [4] = '{127, 123, 1, 244};
  int t3b [4] = '{127, 231, 23, 0};
  int t3z [4] = '{16129, 28413, 23, 0};

  always #5 clk = ~clk;

  mul_unsigned_rr_arb #(
    .WIDTH (WIDTH),
    .NREQ  (NREQ)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_z     (rsp_z),
    .rsp_id    (rsp_id),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  // Advance one clock and move 1 unit past the edge. Registered outputs are then settled.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int ch, input int a, input int b);
    req_a[ch*WIDTH +: WIDTH] = 8'(a);
    req_b[ch*WIDTH +: WIDTH] = 8'(b);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    req_valid = '1;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;

    // 1: reset with all requesters valid
    for (int c = 0; c < 2; c++) begin
      step();
      chk("rst_req_ready", 32'(req_ready), 0);
      chk("rst_rsp_valid", 32'(rsp_valid), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_rsp_z", 32'(rsp_z), 0);
      chk("rst_rsp_id", 32'(rsp_id), 0);
    end
    rst = 1'b0;
    #1;
    chk("rst_first_grant", 32'(req_ready), 1);
    req_valid = '0;
    #1;
    chk("idle_no_req", 32'(req_ready), 0);

    // 2: a single op on ch0, 255*255
    set_op(0, 255, 255);
    rsp_ready = 1'b1;
    req_valid = 4'b0001;
    #1;
    chk("single_grant", 32'(req_ready), 1);
    step();
    req_valid = '0;
    #1;
    chk("single_calc_valid", 32'(rsp_valid), 0);
    chk("single_calc_busy", 32'(busy), 1);
    step();
    chk("single_rsp_valid", 32'(rsp_valid), 1);
    chk("single_rsp_z", 32'(rsp_z), 65025);
    chk("single_rsp_id", 32'(rsp_id), 0);
    step();
    chk("single_done_valid", 32'(rsp_valid), 0);
    chk("single_done_busy", 32'(busy), 0);

    // 3: all four valid, starting from rr_ptr=0
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int c = 0; c < 4; c++) set_op(c, t3a[c], t3b[c]);
    req_valid = 4'b1111;
    for (int g = 0; g < 4; g++) begin
      #1;
      chk("all4_grant", 32'(req_ready), 32'(1) << g);
      step();
      req_valid[g] = 1'b0;
      #1;
      chk("all4_calc_ready", 32'(req_ready), 0);
      step();
      chk("all4_rsp_valid", 32'(rsp_valid), 1);
      chk("all4_rsp_z", 32'(rsp_z), 32'(t3z[g]));
      chk("all4_rsp_id", 32'(rsp_id), 32'(g));
      step();
    end

    // 4: backpressure in RESP. rr_ptr has wrapped to 0, so ch1 wins.
    set_op(1, 200, 3);
    req_valid = 4'b0010;
    rsp_ready = 1'b0;
    #1;
    chk("bp_grant", 32'(req_ready), 2);
    step();
    req_valid = 4'b1111;
    step();
    for (int c = 0; c < 5; c++) begin
      chk("bp_hold_valid", 32'(rsp_valid), 1);
      chk("bp_hold_z", 32'(rsp_z), 600);
      chk("bp_hold_id", 32'(rsp_id), 1);
      chk("bp_hold_ready", 32'(req_ready), 0);
      step();
    end
    rsp_ready = 1'b1;
    step();
    chk("bp_release_valid", 32'(rsp_valid), 0);
    chk("bp_release_busy", 32'(busy), 0);
    chk("bp_next_ptr", 32'(req_ready), 4);
    req_valid = '0;

    // 5: fairness between ch0 and ch2
    rst = 1'b1;
    step();
    rst = 1'b0;
    set_op(0, 3, 5);
    set_op(2, 7, 9);
    req_valid = 4'b0101;
    for (int n = 0; n < 6; n++) begin
      #1;
      chk("fair_grant", 32'(req_ready), (n % 2 == 0) ? 1 : 4);
      step();
      step();
      chk("fair_rsp_id", 32'(rsp_id), (n % 2 == 0) ? 0 : 2);
      chk("fair_rsp_z", 32'(rsp_z), (n % 2 == 0) ? 15 : 63);
      step();
    end
    req_valid = '0;

    // 6: reset while in CALC. rr_ptr is 3 here, so ch3 is granted.
    set_op(3, 10, 10);
    req_valid = 4'b1000;
    #1;
    chk("midrst_grant", 32'(req_ready), 8);
    step();
    req_valid = '0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk("midrst_no_rsp", 32'(rsp_valid), 0);
      chk("midrst_busy", 32'(busy), 0);
      step();
    end
    set_op(0, 2, 3);
    req_valid = 4'b1111;
    #1;
    chk("midrst_ptr0", 32'(req_ready), 1);
    step();
    req_valid = '0;
    step();
    chk("midrst_rsp_z", 32'(rsp_z), 6);
    chk("midrst_rsp_id", 32'(rsp_id), 0);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
